// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl: accepts an N-bit frame over a valid/ready handshake and
// plays it out to a 1-to-N demux, one channel at a time. Each channel is held
// for DWELL cycles. When SEL moves on to the next channel, D is held low for
// BLANK cycles (break-before-make). DONE pulses for one cycle at end of frame.
//
// Handshake: a frame is accepted on a rising CLK edge where VALID=1 and the
// registered READY=1. READY is high only while idle. A VALID seen while READY=0
// is dropped, because there is no queueing.
module demux_scan_ctrl #(
    parameter int N     = 8,
    parameter int SELW  = 3,
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic            CLK,
    input  logic            N_RESET,
    input  logic [N-1:0]    DATA_IN,
    input  logic            VALID,
    output logic            READY,
    input  logic            ABORT,
    output logic            D,
    output logic [SELW-1:0] SEL,
    output logic            BUSY,
    output logic            DONE,
    output logic [1:0]      state_dbg
);

    // A single counter serves both the dwell and blank phases, so it is sized
    // for the longer of the two.
    localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXV) + 1;

    localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0]   BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [SELW-1:0] LAST_SEL   = SELW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_BLANK = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t          state;
    logic [N-1:0]    frame;
    logic [CW-1:0]   cnt;
    logic [SELW-1:0] sel_next;

    // The next channel's index. It is only used while SEL < N-1, so it never
    // points past the frame.
    assign sel_next  = SEL + 1'b1;
    assign state_dbg = state;

    // Sequencer FSM. Every output is registered and is updated together with the state.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state <= S_IDLE;
            frame <= '0;
            cnt   <= '0;
            READY <= 1'b0;
            D     <= 1'b0;
            SEL   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    READY <= 1'b1;
                    BUSY  <= 1'b0;
                    D     <= 1'b0;
                    SEL   <= '0;
                    cnt   <= '0;
                    // ABORT is ignored in idle, so a simultaneous VALID still gets in.
                    if (VALID && READY) begin
                        frame <= DATA_IN;
                        state <= S_DRIVE;
                        D     <= DATA_IN[0];
                        READY <= 1'b0;
                        BUSY  <= 1'b1;
                    end
                end

                S_DRIVE: begin
                    if (ABORT) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        D     <= 1'b0;
                        SEL   <= '0;
                        BUSY  <= 1'b0;
                        READY <= 1'b1;
                    end else if (cnt == DWELL_LAST) begin
                        cnt <= '0;
                        if (SEL == LAST_SEL) begin
                            state <= S_FIN;
                            D     <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            SEL <= sel_next;
                            if (BLANK > 0) begin
                                state <= S_BLANK;
                                D     <= 1'b0;
                            end else begin
                                D <= frame[sel_next];
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_BLANK: begin
                    if (ABORT) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        D     <= 1'b0;
                        SEL   <= '0;
                        BUSY  <= 1'b0;
                        READY <= 1'b1;
                    end else if (cnt == BLANK_LAST) begin
                        state <= S_DRIVE;
                        cnt   <= '0;
                        D     <= frame[SEL];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_FIN: begin
                    // The exit is the same with or without ABORT. DONE is
                    // only ever raised on the edge that enters FIN.
                    state <= S_IDLE;
                    cnt   <= '0;
                    D     <= 1'b0;
                    SEL   <= '0;
                    BUSY  <= 1'b0;
                    READY <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    D     <= 1'b0;
                    SEL   <= '0;
                    BUSY  <= 1'b0;
                    READY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed bench for demux_scan_ctrl with the defaults N=8, DWELL=4, BLANK=1.
// Inputs are driven and outputs sampled on the falling edge of CLK.
module tb_demux_scan_ctrl;

    logic       CLK;
    logic       N_RESET;
    logic [7:0] DATA_IN;
    logic       VALID;
    logic       READY;
    logic       ABORT;
    logic       D;
    logic [2:0] SEL;
    logic       BUSY;
    logic       DONE;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Expected cycle word: {busy, done, d, sel[2:0]}
    logic [5:0] exp_q[$];

    demux_scan_ctrl #(.N(8), .SELW(3), .DWELL(4), .BLANK(1)) dut (
        .CLK       (CLK),
        .N_RESET   (N_RESET),
        .DATA_IN   (DATA_IN),
        .VALID     (VALID),
        .READY     (READY),
        .ABORT     (ABORT),
        .D         (D),
        .SEL       (SEL),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .state_dbg (state_dbg)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of the downstream demux outputs.
    function automatic logic [7:0] demux_y(input logic d, input logic [2:0] s);
        logic [7:0] one;
        one = 8'd1;
        return d ? (one << s) : 8'd0;
    endfunction

    // Hand-derived frame timeline: each channel is driven for 4 cycles,
    // followed by 1 blank cycle (D=0) on the next SEL, and finally FIN.
    task automatic build_expected(input logic [7:0] data);
        exp_q.delete();
        for (int ch = 0; ch < 8; ch++) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back({1'b1, 1'b0, data[ch], 3'(ch)});
            if (ch < 7)
                exp_q.push_back({1'b1, 1'b0, 1'b0, 3'(ch + 1)});
        end
        exp_q.push_back({1'b1, 1'b1, 1'b0, 3'd7});
    endtask

    // Presents a frame while idle and returns at the falling edge of the
    // first busy cycle.
    task automatic start_frame(input logic [7:0] data);
        DATA_IN = data;
        VALID   = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Checks all 40 busy cycles and then the idle cycle that follows them.
    task automatic check_frame(input logic [7:0] data, input string tag);
        logic [5:0] e;
        int idx;
        build_expected(data);
        check($sformatf("%s.len", tag), exp_q.size(), 40);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d].sel", tag, idx), SEL, e[2:0]);
            check($sformatf("%s[%0d].d", tag, idx), D, e[3]);
            check($sformatf("%s[%0d].done", tag, idx), DONE, e[4]);
            check($sformatf("%s[%0d].busy", tag, idx), BUSY, e[5]);
            check($sformatf("%s[%0d].ready", tag, idx), READY, 0);
            check($sformatf("%s[%0d].y", tag, idx), demux_y(D, SEL), demux_y(e[3], e[2:0]));
            idx++;
            @(negedge CLK);
        end
        check($sformatf("%s.idle_busy", tag), BUSY, 0);
        check($sformatf("%s.idle_ready", tag), READY, 1);
        check($sformatf("%s.idle_done", tag), DONE, 0);
        check($sformatf("%s.idle_sel", tag), SEL, 0);
        check($sformatf("%s.idle_d", tag), D, 0);
    endtask

    initial begin
        int done_seen;
        N_RESET = 1'b0;
        DATA_IN = 8'h00;
        VALID   = 1'b0;
        ABORT   = 1'b0;

        // Reset, then release with VALID low.
        repeat (3) @(negedge CLK);
        check("rst_ready", READY, 0);
        check("rst_d", D, 0);
        check("rst_sel", SEL, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_state", state_dbg, 0);
        N_RESET = 1'b1;
        #1;
        check("rel_ready_pre_edge", READY, 0);
        @(negedge CLK);
        check("rel_ready", READY, 1);
        check("rel_busy", BUSY, 0);
        repeat (3) @(negedge CLK);
        check("idle_ready", READY, 1);
        check("idle_sel", SEL, 0);
        check("idle_d", D, 0);

        // Mixed pattern frame.
        start_frame(8'b10100101);
        VALID = 1'b0;
        check_frame(8'b10100101, "a5");

        // All-zero frame.
        start_frame(8'h00);
        VALID = 1'b0;
        check_frame(8'h00, "z0");

        // VALID held during the frame with different data. The frame is unaffected,
        // and the second frame is accepted right after the idle cycle.
        start_frame(8'h5A);
        DATA_IN = 8'h3C;
        check_frame(8'h5A, "ov1");
        start_frame(8'h3C);
        VALID = 1'b0;
        check_frame(8'h3C, "ov2");

        // Abort during the SEL=3 drive phase (busy cycle 15).
        start_frame(8'hFF);
        VALID = 1'b0;
        repeat (15) @(negedge CLK);
        check("ab_pre_sel", SEL, 3);
        check("ab_pre_d", D, 1);
        check("ab_pre_state", state_dbg, 1);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("ab_sel", SEL, 0);
        check("ab_d", D, 0);
        check("ab_ready", READY, 1);
        check("ab_busy", BUSY, 0);
        check("ab_done", DONE, 0);
        check("ab_state", state_dbg, 0);
        done_seen = 0;
        repeat (5) begin
            @(negedge CLK);
            if (DONE) done_seen++;
        end
        check("ab_no_done", done_seen, 0);

        // ABORT in idle together with VALID: the frame is still accepted.
        ABORT = 1'b1;
        start_frame(8'hC3);
        ABORT = 1'b0;
        VALID = 1'b0;
        check_frame(8'hC3, "abi");

        // Asynchronous reset during the SEL=5 drive phase (busy cycle 25).
        start_frame(8'hFF);
        VALID = 1'b0;
        repeat (25) @(negedge CLK);
        check("rm_pre_sel", SEL, 5);
        check("rm_pre_d", D, 1);
        #2 N_RESET = 1'b0;
        #1;
        check("rm_d", D, 0);
        check("rm_sel", SEL, 0);
        check("rm_busy", BUSY, 0);
        check("rm_ready", READY, 0);
        @(negedge CLK);
        N_RESET = 1'b1;
        #1;
        check("rm_ready_pre_edge", READY, 0);
        @(negedge CLK);
        check("rm_ready_edge", READY, 1);
        done_seen = 0;
        repeat (45) begin
            if (DONE) done_seen++;
            @(negedge CLK);
        end
        check("rm_no_done", done_seen, 0);
        check("rm_idle_busy", BUSY, 0);

        // A full frame after the reset.
        start_frame(8'h81);
        VALID = 1'b0;
        check_frame(8'h81, "post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
